// File: rtl/unidade_controle_jogo_pkg.sv
// Shared state codes and control-word layout for the game control unit.
package unidade_controle_jogo_pkg;

  localparam int unsigned ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    FIM_RODADA     = 4'h7,
    PROXIMO_LIMITE = 4'h8,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_l;
    logic conta_l;
    logic zera_r;
    logic registra_r;
    logic conta_t;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } ctrl_t;

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the memory game: sequences rounds, plays, compare and end states.
// Control outputs are registered from the decode of the next state, so they always match db_estado.
module unidade_controle_jogo
  import unidade_controle_jogo_pkg::*;
#(
  parameter int unsigned TIMEOUT_EN = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       botoesIgualMemoria,
  input  logic       endecoIgualLimite,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       contaT,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam logic TIMEOUT_ON = (TIMEOUT_EN != 0);

  estado_t estado_q, estado_d;
  ctrl_t   ctrl_q, ctrl_d;

  // State and control-word registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      ctrl_q   <= '0;
    end else begin
      estado_q <= estado_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:        if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:     estado_d = INICIO_RODADA;
      INICIO_RODADA:  estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A press in the same cycle as the timeout still counts
        if (jogada_feita)                estado_d = REGISTRA;
        else if (timeout && TIMEOUT_ON)  estado_d = FIM_TIMEOUT;
      end
      REGISTRA:       estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!botoesIgualMemoria)     estado_d = FIM_ERROU;
        else if (endecoIgualLimite)  estado_d = FIM_RODADA;
        else                         estado_d = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      FIM_RODADA:     estado_d = fimL ? FIM_ACERTOU : PROXIMO_LIMITE;
      PROXIMO_LIMITE: estado_d = INICIO_RODADA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:    if (iniciar) estado_d = PREPARACAO;
      default:        estado_d = INICIAL;
    endcase
  end

  // Output decode of the state being entered
  always_comb begin
    ctrl_d = '0;
    case (estado_d)
      PREPARACAO: begin
        ctrl_d.zera_e = 1'b1;
        ctrl_d.zera_l = 1'b1;
        ctrl_d.zera_r = 1'b1;
      end
      INICIO_RODADA:  ctrl_d.zera_e     = 1'b1;
      ESPERA_JOGADA:  ctrl_d.conta_t    = 1'b1;
      REGISTRA:       ctrl_d.registra_r = 1'b1;
      PROXIMA_JOGADA: ctrl_d.conta_e    = 1'b1;
      PROXIMO_LIMITE: ctrl_d.conta_l    = 1'b1;
      FIM_ACERTOU: begin
        ctrl_d.pronto = 1'b1;
        ctrl_d.ganhou = 1'b1;
      end
      FIM_ERROU: begin
        ctrl_d.pronto = 1'b1;
        ctrl_d.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        ctrl_d.pronto     = 1'b1;
        ctrl_d.perdeu     = 1'b1;
        ctrl_d.db_timeout = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  assign zeraE      = ctrl_q.zera_e;
  assign contaE     = ctrl_q.conta_e;
  assign zeraL      = ctrl_q.zera_l;
  assign contaL     = ctrl_q.conta_l;
  assign zeraR      = ctrl_q.zera_r;
  assign registraR  = ctrl_q.registra_r;
  assign contaT     = ctrl_q.conta_t;
  assign pronto     = ctrl_q.pronto;
  assign ganhou     = ctrl_q.ganhou;
  assign perdeu     = ctrl_q.perdeu;
  assign db_timeout = ctrl_q.db_timeout;
  assign db_estado  = 4'(estado_q);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed vector bench for the game control unit, with a second instance that ignores timeout.
module tb_unidade_controle_jogo;
  import unidade_controle_jogo_pkg::*;

  // Expected output words: {zeraE,contaE,zeraL,contaL,zeraR,registraR,contaT,pronto,ganhou,perdeu,db_timeout}
  localparam logic [10:0] O_NONE    = 11'h000;
  localparam logic [10:0] O_PREP    = 11'h540;
  localparam logic [10:0] O_INI_R   = 11'h400;
  localparam logic [10:0] O_ESPERA  = 11'h010;
  localparam logic [10:0] O_REG     = 11'h020;
  localparam logic [10:0] O_CONTA_E = 11'h200;
  localparam logic [10:0] O_CONTA_L = 11'h080;
  localparam logic [10:0] O_ACERTOU = 11'h00C;
  localparam logic [10:0] O_ERROU   = 11'h00A;
  localparam logic [10:0] O_TMO     = 11'h00B;

  typedef struct {
    logic       rst;
    logic       ini;
    logic       jog;
    logic       igu;
    logic       lim;
    logic       fim;
    logic       tmo;
    logic [3:0] est;
    logic [10:0] outs;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, iniciar, jogada_feita, botoesIgualMemoria, endecoIgualLimite, fimL, timeout;

  logic zeraE0, contaE0, zeraL0, contaL0, zeraR0, registraR0, contaT0;
  logic pronto0, ganhou0, perdeu0, db_timeout0;
  logic [3:0] db_estado0;
  logic zeraE1, contaE1, zeraL1, contaL1, zeraR1, registraR1, contaT1;
  logic pronto1, ganhou1, perdeu1, db_timeout1;
  logic [3:0] db_estado1;

  logic [14:0] obs0, obs1;
  assign obs0 = {db_estado0, zeraE0, contaE0, zeraL0, contaL0, zeraR0, registraR0, contaT0,
                 pronto0, ganhou0, perdeu0, db_timeout0};
  assign obs1 = {db_estado1, zeraE1, contaE1, zeraL1, contaL1, zeraR1, registraR1, contaT1,
                 pronto1, ganhou1, perdeu1, db_timeout1};

  unidade_controle_jogo #(.TIMEOUT_EN(1)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .botoesIgualMemoria(botoesIgualMemoria), .endecoIgualLimite(endecoIgualLimite),
    .fimL(fimL), .timeout(timeout),
    .zeraE(zeraE0), .contaE(contaE0), .zeraL(zeraL0), .contaL(contaL0),
    .zeraR(zeraR0), .registraR(registraR0), .contaT(contaT0),
    .pronto(pronto0), .ganhou(ganhou0), .perdeu(perdeu0),
    .db_timeout(db_timeout0), .db_estado(db_estado0)
  );

  unidade_controle_jogo #(.TIMEOUT_EN(0)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .botoesIgualMemoria(botoesIgualMemoria), .endecoIgualLimite(endecoIgualLimite),
    .fimL(fimL), .timeout(timeout),
    .zeraE(zeraE1), .contaE(contaE1), .zeraL(zeraL1), .contaL(contaL1),
    .zeraR(zeraR1), .registraR(registraR1), .contaT(contaT1),
    .pronto(pronto1), .ganhou(ganhou1), .perdeu(perdeu1),
    .db_timeout(db_timeout1), .db_estado(db_estado1)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  task automatic push(input logic r, input logic i, input logic j, input logic g,
                      input logic l, input logic f, input logic t,
                      input logic [3:0] e, input logic [10:0] o);
    vec_t v;
    v.rst = r; v.ini = i; v.jog = j; v.igu = g; v.lim = l; v.fim = f; v.tmo = t;
    v.est = e; v.outs = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic i, input logic j, input logic g,
                       input logic l, input logic f, input logic t);
    reset = r; iniciar = i; jogada_feita = j; botoesIgualMemoria = g;
    endecoIgualLimite = l; fimL = f; timeout = t;
  endtask

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got estado=%h outs=%h, expected estado=%h outs=%h",
               name, act[14:11], act[10:0], exp[14:11], exp[10:0]);
    end
  endtask

  task automatic step_check1(input string name, input logic [3:0] e, input logic [10:0] o);
    @(posedge clock); #1;
    check(name, obs1, {e, o});
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    // Bring-up and first round won (round limit not final)
    push(1,0,0,0,0,0,0, INICIAL,        O_NONE);
    push(0,0,0,0,0,0,0, INICIAL,        O_NONE);
    push(0,1,0,0,0,0,0, PREPARACAO,     O_PREP);
    push(0,0,0,0,0,0,0, INICIO_RODADA,  O_INI_R);
    push(0,0,0,0,0,0,0, ESPERA_JOGADA,  O_ESPERA);
    push(0,0,0,0,0,0,0, ESPERA_JOGADA,  O_ESPERA);
    push(0,0,1,0,0,0,0, REGISTRA,       O_REG);
    push(0,0,0,1,1,0,0, COMPARACAO,     O_NONE);
    push(0,0,0,1,1,0,0, FIM_RODADA,     O_NONE);
    push(0,0,0,0,0,0,0, PROXIMO_LIMITE, O_CONTA_L);
    push(0,0,0,0,0,0,0, INICIO_RODADA,  O_INI_R);
    push(0,0,0,0,0,0,0, ESPERA_JOGADA,  O_ESPERA);
    // Round 1: correct first play, then a wrong one
    push(0,0,1,0,0,0,0, REGISTRA,       O_REG);
    push(0,0,0,1,0,0,0, COMPARACAO,     O_NONE);
    push(0,0,0,1,0,0,0, PROXIMA_JOGADA, O_CONTA_E);
    push(0,0,0,0,0,0,0, ESPERA_JOGADA,  O_ESPERA);
    push(0,0,1,0,0,0,0, REGISTRA,       O_REG);
    push(0,0,0,0,0,0,0, COMPARACAO,     O_NONE);
    push(0,0,0,0,1,0,0, FIM_ERROU,      O_ERROU);
    push(0,0,0,0,0,0,0, FIM_ERROU,      O_ERROU);
    // Restart, then lose by timeout
    push(0,1,0,0,0,0,0, PREPARACAO,     O_PREP);
    push(0,0,0,0,0,0,0, INICIO_RODADA,  O_INI_R);
    push(0,0,0,0,0,0,0, ESPERA_JOGADA,  O_ESPERA);
    push(0,0,0,0,0,0,1, FIM_TIMEOUT,    O_TMO);
    push(0,0,0,0,0,0,1, FIM_TIMEOUT,    O_TMO);
    // Restart, simultaneous press and timeout, then win on the final round
    push(0,1,0,0,0,0,0, PREPARACAO,     O_PREP);
    push(0,0,0,0,0,0,0, INICIO_RODADA,  O_INI_R);
    push(0,0,0,0,0,0,0, ESPERA_JOGADA,  O_ESPERA);
    push(0,0,1,0,0,0,1, REGISTRA,       O_REG);
    push(0,0,0,1,1,0,0, COMPARACAO,     O_NONE);
    push(0,0,0,1,1,1,0, FIM_RODADA,     O_NONE);
    push(0,0,0,0,0,1,0, FIM_ACERTOU,    O_ACERTOU);
    push(0,0,0,0,0,0,0, FIM_ACERTOU,    O_ACERTOU);
    // Restart and reset mid-round
    push(0,1,0,0,0,0,0, PREPARACAO,     O_PREP);
    push(0,0,0,0,0,0,0, INICIO_RODADA,  O_INI_R);
    push(0,0,0,0,0,0,0, ESPERA_JOGADA,  O_ESPERA);
    push(0,0,1,0,0,0,0, REGISTRA,       O_REG);
    push(0,0,0,1,0,0,0, COMPARACAO,     O_NONE);
    push(0,0,0,1,0,0,0, PROXIMA_JOGADA, O_CONTA_E);
    push(1,0,0,0,0,0,0, INICIAL,        O_NONE);
    push(1,1,1,1,1,1,1, INICIAL,        O_NONE);
    push(0,0,0,0,0,0,0, INICIAL,        O_NONE);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ini, vecs[i].jog, vecs[i].igu,
            vecs[i].lim, vecs[i].fim, vecs[i].tmo);
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), obs0, {vecs[i].est, vecs[i].outs});
    end

    // TIMEOUT_EN=0 instance ignores timeout while waiting for a play
    drive(1, 0, 0, 0, 0, 0, 0);
    step_check1("noto_reset", INICIAL, O_NONE);
    drive(0, 1, 0, 0, 0, 0, 0);
    step_check1("noto_prep", PREPARACAO, O_PREP);
    drive(0, 0, 0, 0, 0, 0, 0);
    step_check1("noto_inicio", INICIO_RODADA, O_INI_R);
    step_check1("noto_espera", ESPERA_JOGADA, O_ESPERA);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step_check1($sformatf("noto_hold%0d", k), ESPERA_JOGADA, O_ESPERA);
      check($sformatf("to_ends%0d", k), obs0, {4'(FIM_TIMEOUT), O_TMO});
    end
    drive(0, 0, 1, 0, 0, 0, 1);
    step_check1("noto_press", REGISTRA, O_REG);

    // Reset out of a final state
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    check("reset_from_final", obs0, {4'(INICIAL), O_NONE});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogo.md
UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 Parameter TIMEOUT_EN, default 1; 1 = timeout input ends game, 0 = timeout ignored.
REQ-002 clock  in  1  single system clock, all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 iniciar  in  1  start/restart game request (level).
REQ-005 jogada_feita  in  1  one-cycle pulse, button press detected.
REQ-006 botoesIgualMemoria  in  1  registered play equals ROM data.
REQ-007 endecoIgualLimite  in  1  play address equals current round limit.
REQ-008 fimL  in  1  round-limit counter at final value (15).
REQ-009 timeout  in  1  play-timeout counter expired.
REQ-010 zeraE, contaE  out  1 each  clear / increment play-address counter.
REQ-011 zeraL, contaL  out  1 each  clear / increment round-limit counter.
REQ-012 zeraR, registraR  out  1 each  clear / load play register.
REQ-013 contaT  out  1  enable timeout counter (low clears it in the datapath).
REQ-014 pronto, ganhou, perdeu  out  1 each  game finished / won / lost.
REQ-015 db_timeout  out  1  game ended by timeout.
REQ-016 db_estado  out  4  current state code.

Function
REQ-017 Moore FSM; all outputs decoded from current state only; state changes take one clock.
REQ-018 States and codes: inicial 0, preparacao 1, inicio_rodada 2, espera_jogada 3, registra 4, comparacao 5, proxima_jogada 6, fim_rodada 7, proximo_limite 8, fim_acertou A, fim_timeout D, fim_errou E; other codes unused, decode to inicial.
REQ-019 inicial: all outputs 0; iniciar=1 -> preparacao, else stay.
REQ-020 preparacao: zeraE=zeraL=zeraR=1; -> inicio_rodada unconditionally.
REQ-021 inicio_rodada: zeraE=1; -> espera_jogada.
REQ-022 espera_jogada: contaT=1; jogada_feita=1 -> registra; else timeout=1 and TIMEOUT_EN=1 -> fim_timeout; else stay.
REQ-023 Simultaneous jogada_feita and timeout in espera_jogada: jogada_feita wins.
REQ-024 registra: registraR=1; -> comparacao.
REQ-025 comparacao: botoesIgualMemoria=0 -> fim_errou; else endecoIgualLimite=1 -> fim_rodada; else -> proxima_jogada.
REQ-026 proxima_jogada: contaE=1; -> espera_jogada.
REQ-027 fim_rodada: fimL=1 -> fim_acertou; else -> proximo_limite.
REQ-028 proximo_limite: contaL=1; -> inicio_rodada.
REQ-029 fim_acertou: pronto=ganhou=1; fim_errou: pronto=perdeu=1; fim_timeout: pronto=perdeu=db_timeout=1.
REQ-030 Any final state with iniciar=1 -> preparacao (restart without reset); else stay.
REQ-031 contaT is 1 only in espera_jogada, so the timer restarts for every play.
REQ-032 Each contaE/contaL/registraR assertion lasts exactly one cycle per visit.

Reset
REQ-033 reset=1 at a rising edge forces inicial from any state, including mid-round and final states; reset has priority over all inputs.
REQ-034 After reset all outputs 0 and db_estado=0 until iniciar=1.

Structure
REQ-035 State codes (4-bit constants) reside in a shared package used by this block, the top level and the bench.
REQ-036 Single module: state register, next-state logic, output decode; no sub-module.

Verification
REQ-037 reset, then iniciar=1 one cycle -> db_estado 1,2,3 on successive edges; zeraE/zeraL/zeraR=1 in state 1.
REQ-038 Round 0, jogada_feita with igual=1, endecoIgualLimite=1, fimL=0 -> states 4,5,7,8,2,3; contaL pulses once.
REQ-039 In state 3, jogada_feita then igual=0 -> states 4,5,E; pronto=perdeu=1, ganhou=0; stays at E while iniciar=0.
REQ-040 In state 3, timeout=1 (TIMEOUT_EN=1) -> D, db_timeout=1; same with jogada_feita=1 that cycle -> 4; with TIMEOUT_EN=0 -> stays 3.
REQ-041 Full game, fimL=1 at last round -> A, pronto=ganhou=1; iniciar=1 -> 1; reset asserted in state 6 -> 0 next edge, all outputs 0.
